uart_buffered: RTL and testbench
================================

// Module: uart_buffered
// PURPOSE
//  Parametrised successor UART: configurable data width, parity, stop bits, FIFO-buffered RX and TX.
//  Sits between keyboard/host serial pins and the vgaminikbd core.
//  Adds start-glitch rejection, parity/frame/overrun detection and per-direction FIFOs.
//  ECHO mode loops received characters back out through the TX path.
// PARAMETERS
//  DATA_WIDTH  8   data bits per character, legal 5..9
//  PARITY      0   0=none, 1=even, 2=odd
//  STOP_BITS   1   stop bits sent, legal 1..2; RX checks the first stop bit only
//  RX_DEPTH    16  RX FIFO entries, power of two, >=2
//  TX_DEPTH    16  TX FIFO entries, power of two, >=2
// PORTS
//  clk                in   1    system clock
//  rstn               in   1    asynchronous active-low reset
//  UART_RX            in   1    serial input, asynchronous to clk
//  UART_TX            out  1    serial output, idles high
//  ECHO               in   1    1: RX characters are pushed to TX FIFO; host TX writes ignored
//  clockDividerValue  in   20   bit period = clockDividerValue+1 clk cycles; min 3
//  dataInTx           in   DW   character to transmit
//  dataInTxValid      in   1    push request to TX FIFO
//  dataInTxReady      out  1    TX FIFO not full; push happens when valid&ready&~ECHO
//  dataInTxBusy       out  1    TX FIFO non-empty or shifter active
//  dataOutRx          out  DW   RX FIFO head (valid only when dataOutRxAvailable)
//  dataOutRxAvailable out  1    RX FIFO non-empty
//  rxRead             in   1    pop RX FIFO head; ignored when empty
//  rxErrorClear       in   1    clears all sticky error flags
//  rxFrameError       out  1    sticky: stop bit sampled low
//  rxParityError      out  1    sticky: parity mismatch
//  rxOverrun          out  1    sticky: character arrived with RX FIFO full
//  rxBitTick          out  1    1-cycle pulse at each RX sample point
//  txBitTick          out  1    1-cycle pulse at each TX bit boundary
// BEHAVIOUR
//  Reset (async, immediate): UART_TX=1, FIFOs empty, all flags 0, FSMs IDLE, ticks 0, ready=1.
//  RX sync: two-flop synchroniser on UART_RX, reset value 1; FSM sees synchronised bit.
//  RX FSM: IDLE -> START on low; wait (clockDividerValue>>1)+1 cycles, resample:
//   high = glitch -> IDLE, nothing stored; low -> DATA.
//  DATA: DW samples, one per bit period, LSB first. PARITY: one sample if PARITY!=0.
//  STOP: one sample; low sets rxFrameError. Character is pushed to RX FIFO in the STOP sample
//   cycle even on frame/parity error; FSM returns to IDLE same cycle (next start detectable next clk).
//  Parity even: XOR(data,parity bit)=0; odd: =1. Mismatch sets rxParityError.
//  RX FIFO full at push: character dropped, rxOverrun set, FIFO contents unchanged.
//  Push+rxRead same cycle when full: pop frees slot, push accepted, no overrun.
//  Sticky flags: set wins over rxErrorClear in the same cycle.
//  TX FSM: IDLE pops TX FIFO when non-empty -> START(UART_TX=0) -> DATA LSB first -> PARITY
//   (if enabled) -> STOP x STOP_BITS (UART_TX=1) -> IDLE. Each bit held clockDividerValue+1 cycles.
//   Back-to-back characters: next start bit begins the cycle after last stop bit ends.
//  TX latency: push into empty idle FIFO -> UART_TX falls 2 clk later.
//  ECHO: each stored RX character also pushed to TX FIFO; TX FIFO full -> echo dropped (no flag).
//   ECHO change takes effect on next push decision; in-flight TX character always completes.
//  clockDividerValue change mid-character: affects next reload only.
//  Bit counters sized $clog2(DW+4); FIFO pointers one extra bit for full/empty distinction.
// STRUCTURE
//  Shared header vgaminikbd.vh: PARITY_NONE/EVEN/ODD constants, `DELAY.
//  Sub-module uart_sync_fifo (WIDTH, DEPTH): push/pop/full/empty, simultaneous push+pop,
//   head visible combinationally; instantiated twice (RX width DW, TX width DW).
//  RX FSM, TX FSM and error flags stay in uart_buffered.
// TESTING (clockDividerValue=3, i.e. 4 clk/bit, unless noted)
//  1 DW=8,PARITY=0: host pushes 0xA5,0x3C -> UART_TX shows 0,10100101(LSB first),1 then 0x3C
//    with no idle gap; dataInTxBusy drops after final stop.
//  2 Loop UART_TX->UART_RX, PARITY=1(even): send 0x07 -> parity bit 1, dataOutRx=0x07, no errors.
//  3 Drive UART_RX low for 1 clk only -> no FIFO push, no error flags, FSM back to IDLE.
//  4 Inject stop bit low on 0x55 -> 0x55 stored, rxFrameError=1; rxErrorClear -> 0.
//  5 RX_DEPTH=4: receive 5 chars without rxRead -> first 4 kept in order, rxOverrun=1.
//  6 ECHO=1, receive 0x41 -> 0x41 retransmitted on UART_TX; assert rstn=0 mid-frame ->
//    UART_TX=1 immediately, FIFOs empty after release.

Source files
------------

// File: rtl/uart_buffered_pkg.sv
// -----------------------------------------------------------------------------
// uart_buffered_pkg
// Shared definitions for the buffered UART:
//   - parity mode encodings (none / even / odd)
//   - divider width for the bit-period counters
//   - RX and TX state machine encodings
//   - parity_bit(): parity bit value for a given data XOR and mode
// -----------------------------------------------------------------------------
package uart_buffered_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int DIV_W = 20;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Parity bit that makes XOR(data, parity) = 0 (even) or 1 (odd).
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PARITY_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_buffered_if.sv
// -----------------------------------------------------------------------------
// uart_buffered_if
// Host-side bus of the buffered UART: TX push handshake, RX FIFO read port,
// sticky error flags and bit-tick strobes.
//   master : host / core side (drives push data, rxRead, rxErrorClear)
//   slave  : UART side (drives ready/busy, RX head, flags, ticks)
// -----------------------------------------------------------------------------
interface uart_buffered_if #(
    parameter int DW = 8
);
    logic [DW-1:0] dataInTx;
    logic          dataInTxValid;
    logic          dataInTxReady;
    logic          dataInTxBusy;
    logic [DW-1:0] dataOutRx;
    logic          dataOutRxAvailable;
    logic          rxRead;
    logic          rxErrorClear;
    logic          rxFrameError;
    logic          rxParityError;
    logic          rxOverrun;
    logic          rxBitTick;
    logic          txBitTick;

    modport master (
        output dataInTx, dataInTxValid, rxRead, rxErrorClear,
        input  dataInTxReady, dataInTxBusy, dataOutRx, dataOutRxAvailable,
               rxFrameError, rxParityError, rxOverrun, rxBitTick, txBitTick
    );

    modport slave (
        input  dataInTx, dataInTxValid, rxRead, rxErrorClear,
        output dataInTxReady, dataInTxBusy, dataOutRx, dataOutRxAvailable,
               rxFrameError, rxParityError, rxOverrun, rxBitTick, txBitTick
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO used for both UART directions.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   i_push, i_data   write request and data (ignored when full, unless a pop
//                    happens in the same cycle)
//   i_pop            read request (ignored when empty)
//   o_data           head entry, visible combinationally
//   o_full, o_empty  status
// Pointers carry one extra bit so full and empty can be told apart.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_buffered.sv
// -----------------------------------------------------------------------------
// uart_buffered
// FIFO-buffered UART with configurable width, parity and stop bits.
// Ports:
//   clk, rstn          system clock, asynchronous active-low reset
//   UART_RX            serial input (asynchronous, synchronised internally)
//   UART_TX            serial output, idles high
//   ECHO               1: stored RX characters are queued for TX, host pushes ignored
//   clockDividerValue  bit period = clockDividerValue+1 clocks
//   bus                host-side interface (TX push, RX read, flags, ticks)
// RX: start-glitch rejection, mid-bit sampling, parity/frame/overrun sticky flags.
// TX: pops its FIFO and serialises start, data (LSB first), parity, stop bits.
// -----------------------------------------------------------------------------
module uart_buffered
    import uart_buffered_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int RX_DEPTH   = 16,
    parameter int TX_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             UART_RX,
    output logic             UART_TX,
    input  logic             ECHO,
    input  logic [DIV_W-1:0] clockDividerValue,
    uart_buffered_if.slave   bus
);
    localparam int DW  = DATA_WIDTH;
    localparam int BCW = $clog2(DATA_WIDTH + 4);

    // ---------------- RX synchroniser ----------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= UART_RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t        r_rx_state;
    logic [DIV_W-1:0] r_rx_cnt;
    logic [BCW-1:0]   r_rx_bit;
    logic [DW-1:0]    r_rx_shift;
    logic             r_rx_par;
    logic             r_rx_tick;
    logic             w_rx_cnt_zero;
    logic             w_rx_sample;
    logic             w_rx_push;

    assign w_rx_cnt_zero = (r_rx_cnt == '0);
    assign w_rx_sample   = (r_rx_state != RX_IDLE) && w_rx_cnt_zero;
    // The character is complete at the stop-bit sample; it is stored then,
    // whatever the error status.
    assign w_rx_push     = (r_rx_state == RX_STOP) && w_rx_cnt_zero;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_tick  <= 1'b0;
        end else begin
            r_rx_tick <= w_rx_sample;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_state <= RX_START;
                        // Land the resample in the middle of the start bit.
                        r_rx_cnt   <= clockDividerValue >> 1;
                    end
                end
                RX_START: begin
                    if (w_rx_cnt_zero) begin
                        if (r_rx_sync) begin
                            r_rx_state <= RX_IDLE;   // glitch: line back high
                        end else begin
                            r_rx_state <= RX_DATA;
                            r_rx_cnt   <= clockDividerValue;
                            r_rx_bit   <= '0;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_cnt_zero) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DW-1:1]};
                        r_rx_cnt   <= clockDividerValue;
                        if (r_rx_bit == BCW'(DW - 1)) begin
                            r_rx_state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (w_rx_cnt_zero) begin
                        r_rx_par   <= r_rx_sync;
                        r_rx_cnt   <= clockDividerValue;
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_cnt_zero) begin
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO and error flags ----------------
    logic [DW-1:0] w_rx_head;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_rx_pop_ok;
    logic          w_rx_stored;
    logic          w_fe_set;
    logic          w_pe_set;
    logic          w_ov_set;
    logic          r_frame_err;
    logic          r_parity_err;
    logic          r_overrun;

    assign w_rx_pop_ok = bus.rxRead & ~w_rx_empty;
    assign w_rx_stored = w_rx_push & (~w_rx_full | w_rx_pop_ok);
    assign w_fe_set    = w_rx_push & ~r_rx_sync;
    assign w_pe_set    = w_rx_push && (PARITY != PARITY_NONE) &&
                         (r_rx_par != parity_bit(^r_rx_shift, PARITY));
    assign w_ov_set    = w_rx_push & ~w_rx_stored;

    uart_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (bus.rxRead),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // Setting a flag takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_fe_set)              r_frame_err  <= 1'b1;
            else if (bus.rxErrorClear) r_frame_err  <= 1'b0;
            if (w_pe_set)              r_parity_err <= 1'b1;
            else if (bus.rxErrorClear) r_parity_err <= 1'b0;
            if (w_ov_set)              r_overrun    <= 1'b1;
            else if (bus.rxErrorClear) r_overrun    <= 1'b0;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DW-1:0] w_tx_head;
    logic [DW-1:0] w_tx_push_data;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_tx_push;
    logic          w_tx_pop;

    // In ECHO mode only stored RX characters feed TX; if TX is full the echo is lost.
    assign w_tx_push      = ECHO ? w_rx_stored : (bus.dataInTxValid & ~w_tx_full);
    assign w_tx_push_data = ECHO ? r_rx_shift  : bus.dataInTx;

    uart_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_tx_push),
        .i_data  (w_tx_push_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    // ---------------- TX FSM ----------------
    tx_state_t        r_tx_state;
    logic [DIV_W-1:0] r_tx_cnt;
    logic [BCW-1:0]   r_tx_bit;
    logic [DW-1:0]    r_tx_shift;
    logic             r_tx_par;
    logic             r_tx;
    logic             r_tx_tick;
    logic             w_tx_cnt_zero;
    logic             w_tx_last_stop;

    assign w_tx_cnt_zero  = (r_tx_cnt == '0);
    assign w_tx_last_stop = (r_tx_state == TX_STOP) && w_tx_cnt_zero &&
                            (r_tx_bit == BCW'(STOP_BITS - 1));
    // Popping at the end of the last stop bit gives back-to-back frames.
    assign w_tx_pop       = ~w_tx_empty & ((r_tx_state == TX_IDLE) | w_tx_last_stop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_tick  <= 1'b0;
        end else begin
            r_tx_tick <= 1'b0;
            if (w_tx_pop) begin
                r_tx_state <= TX_START;
                r_tx       <= 1'b0;
                r_tx_cnt   <= clockDividerValue;
                r_tx_bit   <= '0;
                r_tx_shift <= w_tx_head;
                r_tx_par   <= parity_bit(^w_tx_head, PARITY);
                r_tx_tick  <= 1'b1;
            end else begin
                case (r_tx_state)
                    TX_IDLE: r_tx <= 1'b1;
                    TX_START: begin
                        if (w_tx_cnt_zero) begin
                            r_tx_state <= TX_DATA;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_cnt   <= clockDividerValue;
                            r_tx_tick  <= 1'b1;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (w_tx_cnt_zero) begin
                            r_tx_cnt  <= clockDividerValue;
                            r_tx_tick <= 1'b1;
                            if (r_tx_bit == BCW'(DW - 1)) begin
                                r_tx_bit <= '0;
                                if (PARITY != PARITY_NONE) begin
                                    r_tx_state <= TX_PARITY;
                                    r_tx       <= r_tx_par;
                                end else begin
                                    r_tx_state <= TX_STOP;
                                    r_tx       <= 1'b1;
                                end
                            end else begin
                                r_tx_bit   <= r_tx_bit + 1'b1;
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= r_tx_shift >> 1;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    TX_PARITY: begin
                        if (w_tx_cnt_zero) begin
                            r_tx_state <= TX_STOP;
                            r_tx       <= 1'b1;
                            r_tx_cnt   <= clockDividerValue;
                            r_tx_bit   <= '0;
                            r_tx_tick  <= 1'b1;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    TX_STOP: begin
                        if (w_tx_cnt_zero) begin
                            if (w_tx_last_stop) begin
                                r_tx_state <= TX_IDLE;
                            end else begin
                                r_tx_bit  <= r_tx_bit + 1'b1;
                                r_tx_cnt  <= clockDividerValue;
                                r_tx_tick <= 1'b1;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_tx_state <= TX_IDLE;
                        r_tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- Outputs ----------------
    assign UART_TX                = r_tx;
    assign bus.dataInTxReady      = ~w_tx_full;
    assign bus.dataInTxBusy       = ~w_tx_empty | (r_tx_state != TX_IDLE);
    assign bus.dataOutRx          = w_rx_head;
    assign bus.dataOutRxAvailable = ~w_rx_empty;
    assign bus.rxFrameError       = r_frame_err;
    assign bus.rxParityError      = r_parity_err;
    assign bus.rxOverrun          = r_overrun;
    assign bus.rxBitTick          = r_rx_tick;
    assign bus.txBitTick          = r_tx_tick;

endmodule

// File: tb/tb_uart_buffered.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_buffered
// Two instances: A (8N1, RX depth 4, ECHO controllable, RX driven by the bench)
// and B (8E2, TX looped back into RX). Expected characters are queued when
// stimulus is driven and popped when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_uart_buffered;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_a;
    logic        tx_a;
    logic        echo_a;
    logic        tx_b;
    logic [19:0] div = 20'd3;

    always #5 clk = ~clk;

    uart_buffered_if #(.DW(8)) if_a ();
    uart_buffered_if #(.DW(8)) if_b ();

    uart_buffered #(
        .DATA_WIDTH (8), .PARITY (0), .STOP_BITS (1), .RX_DEPTH (4), .TX_DEPTH (16)
    ) u_dut_a (
        .clk               (clk),
        .rstn              (rstn),
        .UART_RX           (rx_a),
        .UART_TX           (tx_a),
        .ECHO              (echo_a),
        .clockDividerValue (div),
        .bus               (if_a)
    );

    uart_buffered #(
        .DATA_WIDTH (8), .PARITY (1), .STOP_BITS (2), .RX_DEPTH (16), .TX_DEPTH (16)
    ) u_dut_b (
        .clk               (clk),
        .rstn              (rstn),
        .UART_RX           (tx_b),
        .UART_TX           (tx_b),
        .ECHO              (1'b0),
        .clockDividerValue (div),
        .bus               (if_b)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         rxtick_a = 0;
    int         txtick_a = 0;
    bit         mon_en   = 1'b1;
    logic [7:0] tx_exp_q [$];
    logic [7:0] rxa_q    [$];
    logic [7:0] rxb_q    [$];
    int         start_cyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (if_a.rxBitTick) rxtick_a <= rxtick_a + 1;
        if (if_a.txBitTick) txtick_a <= txtick_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive one 8N1 frame into A, then idle high for two bit periods.
    task automatic send_rx_a(input logic [7:0] d, input logic stop_val);
        logic [9:0] fr;
        fr = {stop_val, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_a = fr[k];
            repeat (4) @(negedge clk);
        end
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Pop everything in A's RX FIFO against the scoreboard.
    task automatic drain_a();
        int n;
        n = 0;
        while (if_a.dataOutRxAvailable && n < 8) begin
            if (rxa_q.size() == 0) chk("rx_a_extra", {24'd0, if_a.dataOutRx}, 32'h1FF);
            else chk("rx_a_char", {24'd0, if_a.dataOutRx}, {24'd0, rxa_q.pop_front()});
            if_a.rxRead = 1'b1;
            @(negedge clk);
            if_a.rxRead = 1'b0;
            n++;
        end
        chk("rx_a_left", rxa_q.size(), 0);
    endtask

    task automatic clear_err_a();
        if_a.rxErrorClear = 1'b1;
        @(negedge clk);
        if_a.rxErrorClear = 1'b0;
    endtask

    // Serial monitor on A's TX: samples mid-bit, 4 clocks per bit.
    initial begin : mon_a
        logic [9:0] fr;
        forever begin
            @(negedge clk);
            if (mon_en && rstn && tx_a === 1'b0) begin
                start_cyc.push_back(cyc);
                repeat (2) @(negedge clk);
                fr[0] = tx_a;
                for (int k = 1; k < 10; k++) begin
                    repeat (4) @(negedge clk);
                    fr[k] = tx_a;
                end
                if (tx_exp_q.size() == 0) chk("tx_unexpected", {24'd0, fr[8:1]}, 32'h1FF);
                else chk("tx_char", {24'd0, fr[8:1]}, {24'd0, tx_exp_q.pop_front()});
                chk("tx_stop", {31'd0, fr[9]}, 1);
            end
        end
    end

    initial begin : main
        int         w;
        int         snap;
        logic [11:0] bits;

        rx_a = 1'b1;
        echo_a = 1'b0;
        if_a.dataInTx = '0; if_a.dataInTxValid = 1'b0; if_a.rxRead = 1'b0; if_a.rxErrorClear = 1'b0;
        if_b.dataInTx = '0; if_b.dataInTxValid = 1'b0; if_b.rxRead = 1'b0; if_b.rxErrorClear = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx",    {31'd0, tx_a}, 1);
        chk("rst_ready", {31'd0, if_a.dataInTxReady}, 1);
        chk("rst_avail", {31'd0, if_a.dataOutRxAvailable}, 0);
        chk("rst_busy",  {31'd0, if_a.dataInTxBusy}, 0);
        chk("rst_flags", {29'd0, if_a.rxFrameError, if_a.rxParityError, if_a.rxOverrun}, 0);
        chk("rst_ticks", {30'd0, if_a.rxBitTick, if_a.txBitTick}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: two host pushes, back-to-back frames, 2-clock latency
        snap = txtick_a;
        if_a.dataInTx = 8'hA5; if_a.dataInTxValid = 1'b1; tx_exp_q.push_back(8'hA5);
        @(negedge clk);
        chk("t1_lat1", {31'd0, tx_a}, 1);
        if_a.dataInTx = 8'h3C; tx_exp_q.push_back(8'h3C);
        @(negedge clk);
        chk("t1_lat2", {31'd0, tx_a}, 0);
        if_a.dataInTxValid = 1'b0;
        w = 0;
        while (if_a.dataInTxBusy && w < 200) begin @(negedge clk); w++; end
        chk("t1_busy_bound", {31'd0, if_a.dataInTxBusy}, 0);
        chk("t1_nstarts", start_cyc.size(), 2);
        if (start_cyc.size() >= 2) begin
            chk("t1_gap",       start_cyc[1] - start_cyc[0], 40);
            chk("t1_busy_drop", cyc - start_cyc[1], 40);
        end
        chk("t1_txq_empty", tx_exp_q.size(), 0);
        chk("t1_txticks", txtick_a - snap, 20);
        chk("t1_tx_idle", {31'd0, tx_a}, 1);

        // Test 2: B loopback, even parity, two stop bits
        if_b.dataInTx = 8'h07; if_b.dataInTxValid = 1'b1; rxb_q.push_back(8'h07);
        @(negedge clk);
        if_b.dataInTxValid = 1'b0;
        w = 0;
        while (tx_b !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        chk("t2_start", {31'd0, tx_b}, 0);
        repeat (2) @(negedge clk);
        bits[0] = tx_b;
        for (int k = 1; k < 12; k++) begin
            repeat (4) @(negedge clk);
            bits[k] = tx_b;
        end
        chk("t2_data",   {24'd0, bits[8:1]}, 32'h07);
        chk("t2_parity", {31'd0, bits[9]}, 1);
        chk("t2_stops",  {30'd0, bits[11:10]}, 3);
        w = 0;
        while (!if_b.dataOutRxAvailable && w < 50) begin @(negedge clk); w++; end
        chk("t2_avail", {31'd0, if_b.dataOutRxAvailable}, 1);
        if (rxb_q.size() > 0) chk("t2_rx_char", {24'd0, if_b.dataOutRx}, {24'd0, rxb_q.pop_front()});
        chk("t2_flags", {29'd0, if_b.rxFrameError, if_b.rxParityError, if_b.rxOverrun}, 0);
        if_b.rxRead = 1'b1;
        @(negedge clk);
        if_b.rxRead = 1'b0;
        chk("t2_empty", {31'd0, if_b.dataOutRxAvailable}, 0);

        // Test 3: one-clock low glitch on RX
        snap = rxtick_a;
        rx_a = 1'b0;
        @(negedge clk);
        rx_a = 1'b1;
        repeat (12) @(negedge clk);
        chk("t3_avail", {31'd0, if_a.dataOutRxAvailable}, 0);
        chk("t3_flags", {29'd0, if_a.rxFrameError, if_a.rxParityError, if_a.rxOverrun}, 0);
        chk("t3_ticks", rxtick_a - snap, 1);

        // Test 4: stop bit low on 0x55
        rxa_q.push_back(8'h55);
        send_rx_a(8'h55, 1'b0);
        chk("t4_frame", {31'd0, if_a.rxFrameError}, 1);
        chk("t4_parity", {31'd0, if_a.rxParityError}, 0);
        drain_a();
        clear_err_a();
        chk("t4_cleared", {31'd0, if_a.rxFrameError}, 0);

        // Test 5: five characters into a 4-deep RX FIFO
        snap = rxtick_a;
        rxa_q.push_back(8'h11);
        send_rx_a(8'h11, 1'b1);
        chk("t5_rxticks", rxtick_a - snap, 10);
        rxa_q.push_back(8'h22); send_rx_a(8'h22, 1'b1);
        rxa_q.push_back(8'h33); send_rx_a(8'h33, 1'b1);
        rxa_q.push_back(8'h44); send_rx_a(8'h44, 1'b1);
        chk("t5_no_ov", {31'd0, if_a.rxOverrun}, 0);
        send_rx_a(8'h5A, 1'b1);
        chk("t5_ov",    {31'd0, if_a.rxOverrun}, 1);
        chk("t5_frame", {31'd0, if_a.rxFrameError}, 0);
        drain_a();
        clear_err_a();
        chk("t5_ov_clr", {31'd0, if_a.rxOverrun}, 0);

        // Test 6: ECHO, host write ignored, then reset mid-frame
        echo_a = 1'b1;
        @(negedge clk);
        if_a.dataInTx = 8'h99; if_a.dataInTxValid = 1'b1;
        @(negedge clk);
        if_a.dataInTxValid = 1'b0;
        chk("t6_host_ignored", {31'd0, if_a.dataInTxBusy}, 0);
        rxa_q.push_back(8'h41); tx_exp_q.push_back(8'h41);
        send_rx_a(8'h41, 1'b1);
        w = 0;
        while ((tx_exp_q.size() != 0 || if_a.dataInTxBusy) && w < 100) begin @(negedge clk); w++; end
        chk("t6_echo_done", tx_exp_q.size(), 0);
        drain_a();
        mon_en = 1'b0;
        send_rx_a(8'h42, 1'b1);
        w = 0;
        while (tx_a !== 1'b0 && w < 40) begin @(negedge clk); w++; end
        chk("t6_midframe_low", {31'd0, tx_a}, 0);
        chk("t6_busy_mid", {31'd0, if_a.dataInTxBusy}, 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_tx",    {31'd0, tx_a}, 1);
        chk("t6_rst_busy",  {31'd0, if_a.dataInTxBusy}, 0);
        chk("t6_rst_avail", {31'd0, if_a.dataOutRxAvailable}, 0);
        @(negedge clk);
        rstn = 1'b1;
        echo_a = 1'b0;
        snap = txtick_a;
        repeat (50) @(negedge clk);
        chk("t6_post_ready", {31'd0, if_a.dataInTxReady}, 1);
        chk("t6_post_avail", {31'd0, if_a.dataOutRxAvailable}, 0);
        chk("t6_post_tx",    {31'd0, tx_a}, 1);
        chk("t6_post_ticks", txtick_a - snap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
